// File: rtl/nvp_ctrl_regfile_if.sv
// AXI-Lite control bus between the PS/host master and the NVP register bank.
interface nvp_ctrl_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/nvp_ctrl_regfile.sv
// NVP control/status register bank behind an AXI-Lite slave.
// Define NVP_CTRL_STAT_STICKY_EN for sticky, write-1-to-clear status registers.
module nvp_ctrl_regfile #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned N_CTRL             = 8,
    parameter int unsigned N_STAT             = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] CTRL_RST_VAL = 32'h0
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    nvp_ctrl_regfile_if.slave                    s_axi,
    output logic [N_CTRL*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    output logic [N_CTRL-1:0]                    ctrl_wr_pulse_o,
    input  logic [N_STAT*C_S_AXI_DATA_WIDTH-1:0] stat_i
);
    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned N_REGS = N_CTRL + N_STAT;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_RESP = 2'd1, W_BUSY = 2'd2} wstate_e;

    wstate_e           state_q, state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs_c, w_hs_c, commit_c;
    logic [IDX_W-1:0]  aw_idx_c, cm_idx_c, ar_idx_c;
    logic [DW-1:0]     cm_data_c;
    logic [SW-1:0]     cm_strb_c;
    logic [N_CTRL-1:0][DW-1:0] ctrl_words;
    logic [N_STAT-1:0][DW-1:0] stat_word_c;
    logic              unused_addr_lsb;

    assign aw_hs_c   = s_axi.AWVALID & awready_q;
    assign w_hs_c    = s_axi.WVALID & wready_q;
    assign aw_idx_c  = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx_c  = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_addr_lsb = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

    // Write FSM: W_BUSY is the post-reset settle state before the readies open.
    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit_c  = 1'b0;
        cm_idx_c  = aw_held_q ? aw_idx_q : aw_idx_c;
        cm_data_c = w_held_q ? wdata_q : s_axi.WDATA;
        cm_strb_c = w_held_q ? wstrb_q : s_axi.WSTRB;
        unique case (state_q)
            W_BUSY: begin
                state_d   = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b1;
            end
            W_IDLE: begin
                if (aw_hs_c) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = aw_idx_c;
                end
                if (w_hs_c) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi.WDATA;
                    wstrb_d  = s_axi.WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    commit_c = 1'b1;
                    state_d  = W_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = (cm_idx_c >= IDX_W'(N_REGS)) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (s_axi.BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    state_d   = W_IDLE;
                end
            end
            default: state_d = W_BUSY;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= W_BUSY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Control registers, stored per byte lane so strobes map directly to enables.
    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl
        logic sel_c;
        logic pulse_q;
        assign sel_c = commit_c && (cm_idx_c == IDX_W'(k));
        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) pulse_q <= 1'b0;
            else              pulse_q <= sel_c;
        end
        assign ctrl_wr_pulse_o[k] = pulse_q;
        for (genvar b = 0; b < SW; b++) begin : g_byte
            logic [7:0] byte_q;
            always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
                if (S_AXI_ARESET)                byte_q <= CTRL_RST_VAL[8*b +: 8];
                else if (sel_c && cm_strb_c[b]) byte_q <= cm_data_c[8*b +: 8];
            end
            assign ctrl_words[k][8*b +: 8] = byte_q;
        end
    end
    assign ctrl_o = ctrl_words;

`ifdef NVP_CTRL_STAT_STICKY_EN
    // Sticky status: new set bits win over a same-cycle write-1-to-clear.
    logic [N_STAT-1:0][DW-1:0] stat_q, stat_clr_c;
    logic [DW-1:0]             strb_mask_c;
    for (genvar b = 0; b < SW; b++) begin : g_mask
        assign strb_mask_c[8*b +: 8] = {8{cm_strb_c[b]}};
    end
    for (genvar s = 0; s < N_STAT; s++) begin : g_clr
        assign stat_clr_c[s] = (commit_c && (cm_idx_c == IDX_W'(N_CTRL + s))) ?
                               (cm_data_c & strb_mask_c) : '0;
    end
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) stat_q <= '0;
        else              stat_q <= (stat_q & ~stat_clr_c) | stat_i;
    end
    assign stat_word_c = stat_q;
`else
    assign stat_word_c = stat_i;
`endif

    // Read mux as a one-hot AND-OR over every mapped word.
    logic [N_REGS-1:0]         rd_hit_c;
    logic [N_REGS-1:0][DW-1:0] rd_src_c;
    logic [DW-1:0][N_REGS-1:0] rd_masked_c;
    logic [DW-1:0]             rd_word_c;
    for (genvar r = 0; r < N_REGS; r++) begin : g_rd
        assign rd_hit_c[r] = (ar_idx_c == IDX_W'(r));
        if (r < N_CTRL) begin : g_c
            assign rd_src_c[r] = ctrl_words[r];
        end else begin : g_s
            assign rd_src_c[r] = stat_word_c[r - N_CTRL];
        end
        for (genvar j = 0; j < DW; j++) begin : g_bit
            assign rd_masked_c[j][r] = rd_hit_c[r] & rd_src_c[r][j];
        end
    end
    for (genvar j = 0; j < DW; j++) begin : g_or
        assign rd_word_c[j] = |rd_masked_c[j];
    end

    logic          arready_q, rvalid_q, rvalid_d, ar_hs_c;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    assign ar_hs_c = s_axi.ARVALID & arready_q;

    always_comb begin
        rvalid_d = rvalid_q;
        if (ar_hs_c)                     rvalid_d = 1'b1;
        else if (rvalid_q && s_axi.RREADY) rvalid_d = 1'b0;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= !rvalid_d;
            rvalid_q  <= rvalid_d;
            if (ar_hs_c) begin
                rdata_q <= rd_word_c;
                rresp_q <= (ar_idx_c >= IDX_W'(N_REGS)) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
endmodule

// File: tb/tb_nvp_ctrl_regfile.sv
// Self-checking bench for nvp_ctrl_regfile: vector table plus hand-written corner sequences.
module tb_nvp_ctrl_regfile;
    localparam int unsigned N_CTRL = 8;
    localparam int unsigned N_STAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_CTRL*32-1:0] ctrl_o;
    logic [N_CTRL-1:0]    ctrl_wr_pulse;
    logic [N_STAT*32-1:0] stat_i;

    nvp_ctrl_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    nvp_ctrl_regfile #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8),
        .N_CTRL(N_CTRL), .N_STAT(N_STAT), .CTRL_RST_VAL(32'h0)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus),
        .ctrl_o(ctrl_o), .ctrl_wr_pulse_o(ctrl_wr_pulse), .stat_i(stat_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] resp; logic [31:0] data; } exp_t;
    typedef struct packed {
        logic       is_rd;
        logic [7:0] addr;
        logic [31:0] wdata;
        logic [3:0] strb;
        logic [3:0] lead;
        logic [1:0] resp;
        logic [31:0] data;
        logic [7:0] pulse;
    } vec_t;

    exp_t bq[$];
    exp_t rq[$];
    vec_t vecs[18];
    int   n_vec = 0;
    int   n_err = 0;
    logic [N_CTRL-1:0][31:0] model;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out or missing expectation", name);
    endtask

    // Issues one write; W may lead AW by 'lead' idle cycles. Caller updates the model first.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input logic [1:0] resp, input logic [7:0] pulse);
        bit   aw_done = 0, w_done = 0, hs_aw, hs_w;
        int   cyc = 0;
        exp_t e;
        e.resp = resp;
        e.data = 32'h0;
        bq.push_back(e);
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
        if (lead == 0) begin bus.AWADDR = addr; bus.AWVALID = 1'b1; end
        while (!(aw_done && w_done) && cyc < 20) begin
            hs_aw = bus.AWVALID && bus.AWREADY;
            hs_w  = bus.WVALID && bus.WREADY;
            @(negedge clk);
            cyc++;
            if (hs_aw) begin bus.AWVALID = 1'b0; aw_done = 1; end
            if (hs_w) begin
                bus.WVALID = 1'b0;
                w_done = 1;
                if (!aw_done && !bus.AWVALID) begin
                    for (int i = 0; i < lead; i++) begin
                        check("no_early_b", 256'(bus.BVALID), 256'(1'b0));
                        @(negedge clk);
                    end
                    bus.AWADDR = addr; bus.AWVALID = 1'b1;
                end
            end
        end
        if (!(aw_done && w_done)) begin
            bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
            fail_now("write_handshake");
            return;
        end
        check("bvalid", 256'(bus.BVALID), 256'(1'b1));
        if (bq.size() != 0) begin
            e = bq.pop_front();
            check("bresp", 256'(bus.BRESP), 256'(e.resp));
        end else fail_now("bresp_queue");
        check("wr_pulse", 256'(ctrl_wr_pulse), 256'(pulse));
        check("ctrl_o", 256'(ctrl_o), 256'(model));
        @(negedge clk);
        check("bvalid_clear", 256'(bus.BVALID), 256'(1'b0));
        check("pulse_clear", 256'(ctrl_wr_pulse), 256'(0));
    endtask

    // Issues one read; RREADY is held low for 'hold' cycles once RVALID is up.
    task automatic axi_read(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input int hold);
        bit   done = 0, hs;
        int   cyc = 0;
        exp_t e;
        e.resp = resp;
        e.data = data;
        rq.push_back(e);
        bus.RREADY = (hold == 0);
        bus.ARADDR = addr; bus.ARVALID = 1'b1;
        while (!done && cyc < 20) begin
            hs = bus.ARVALID && bus.ARREADY;
            @(negedge clk);
            cyc++;
            if (hs) begin bus.ARVALID = 1'b0; done = 1; end
        end
        if (!done) begin
            bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
            fail_now("read_handshake");
            return;
        end
        e = rq.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("rvalid_hold", 256'(bus.RVALID), 256'(1'b1));
            check("rdata_hold", 256'(bus.RDATA), 256'(e.data));
            check("arready_low", 256'(bus.ARREADY), 256'(1'b0));
            @(negedge clk);
        end
        bus.RREADY = 1'b1;
        check("rvalid", 256'(bus.RVALID), 256'(1'b1));
        check("rdata", 256'(bus.RDATA), 256'(e.data));
        check("rresp", 256'(bus.RRESP), 256'(e.resp));
        @(negedge clk);
        check("rvalid_clear", 256'(bus.RVALID), 256'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vecs[0]  = '{1'b0, 8'h04, 32'hDEADBEEF, 4'hF, 4'd0, 2'b00, 32'hDEADBEEF, 8'h02};
        vecs[1]  = '{1'b0, 8'h00, 32'h12345678, 4'h5, 4'd3, 2'b00, 32'h00340078, 8'h01};
        vecs[2]  = '{1'b1, 8'h00, 32'h0,        4'h0, 4'd0, 2'b00, 32'h00340078, 8'h00};
        vecs[3]  = '{1'b1, 8'h04, 32'h0,        4'h0, 4'd0, 2'b00, 32'hDEADBEEF, 8'h00};
        vecs[4]  = '{1'b0, 8'h08, 32'h11223344, 4'h3, 4'd0, 2'b00, 32'h00003344, 8'h04};
        vecs[5]  = '{1'b0, 8'h0B, 32'hAABBCCDD, 4'hC, 4'd1, 2'b00, 32'hAABB3344, 8'h04};
        vecs[6]  = '{1'b1, 8'h09, 32'h0,        4'h0, 4'd0, 2'b00, 32'hAABB3344, 8'h00};
        vecs[7]  = '{1'b0, 8'h1C, 32'hCAFEF00D, 4'hF, 4'd0, 2'b00, 32'hCAFEF00D, 8'h80};
        vecs[8]  = '{1'b1, 8'h1C, 32'h0,        4'h0, 4'd0, 2'b00, 32'hCAFEF00D, 8'h00};
        vecs[9]  = '{1'b0, 8'h40, 32'hFFFFFFFF, 4'hF, 4'd0, 2'b10, 32'h0,        8'h00};
        vecs[10] = '{1'b1, 8'h40, 32'h0,        4'h0, 4'd0, 2'b10, 32'h0,        8'h00};
        vecs[11] = '{1'b1, 8'h2C, 32'h0,        4'h0, 4'd0, 2'b00, 32'h5A5A0001, 8'h00};
        vecs[12] = '{1'b0, 8'h2C, 32'hFFFFFFFF, 4'hF, 4'd0, 2'b00, 32'h0,        8'h00};
        vecs[13] = '{1'b1, 8'h2C, 32'h0,        4'h0, 4'd0, 2'b00, 32'h5A5A0001, 8'h00};
        vecs[14] = '{1'b1, 8'h30, 32'h0,        4'h0, 4'd0, 2'b10, 32'h0,        8'h00};
        vecs[15] = '{1'b1, 8'hFF, 32'h0,        4'h0, 4'd0, 2'b10, 32'h0,        8'h00};
        vecs[16] = '{1'b0, 8'h04, 32'h00000000, 4'h0, 4'd0, 2'b00, 32'hDEADBEEF, 8'h02};
        vecs[17] = '{1'b1, 8'h04, 32'h0,        4'h0, 4'd0, 2'b00, 32'hDEADBEEF, 8'h00};

        model = '0;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
        stat_i = {32'h5A5A0001, 96'h0};
        rst = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_awready", 256'(bus.AWREADY), 256'(1'b0));
        check("rst_wready", 256'(bus.WREADY), 256'(1'b0));
        check("rst_arready", 256'(bus.ARREADY), 256'(1'b0));
        check("rst_bvalid", 256'(bus.BVALID), 256'(1'b0));
        check("rst_rvalid", 256'(bus.RVALID), 256'(1'b0));
        check("rst_bresp", 256'(bus.BRESP), 256'(2'b00));
        check("rst_rresp", 256'(bus.RRESP), 256'(2'b00));
        check("rst_rdata", 256'(bus.RDATA), 256'(32'h0));
        check("rst_ctrl_o", 256'(ctrl_o), 256'(0));
        check("rst_pulse", 256'(ctrl_wr_pulse), 256'(0));
        rst = 1'b0;
        check("awready_before_edge", 256'(bus.AWREADY), 256'(1'b0));
        @(negedge clk);
        check("awready_first", 256'(bus.AWREADY), 256'(1'b1));
        check("wready_first", 256'(bus.WREADY), 256'(1'b1));
        check("arready_first", 256'(bus.ARREADY), 256'(1'b1));

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_rd) begin
                axi_read(vecs[i].addr, vecs[i].data, vecs[i].resp, 0);
            end else begin
                for (int k = 0; k < int'(N_CTRL); k++)
                    if (vecs[i].pulse[k]) model[k] = vecs[i].data;
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, int'(vecs[i].lead),
                          vecs[i].resp, vecs[i].pulse);
            end
        end

`ifdef NVP_CTRL_STAT_STICKY_EN
        stat_i[3] = 1'b1;
        @(negedge clk);
        stat_i[3] = 1'b0;
        axi_read(8'h20, 32'h8, 2'b00, 0);
        axi_write(8'h20, 32'h8, 4'hF, 0, 2'b00, 8'h00);
        axi_read(8'h20, 32'h0, 2'b00, 0);
`endif
        stat_i[31:0] = 32'hA5;
        @(negedge clk);
        axi_read(8'h20, 32'hA5, 2'b00, 4);

        // Write commit and read handshake to the same register on the same edge.
        check("same_awready", 256'(bus.AWREADY), 256'(1'b1));
        check("same_wready", 256'(bus.WREADY), 256'(1'b1));
        check("same_arready", 256'(bus.ARREADY), 256'(1'b1));
        e.resp = 2'b00; e.data = 32'h0;
        bq.push_back(e);
        rq.push_back(e);
        model[3] = 32'h77;
        bus.AWADDR = 8'h0C; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = 8'h0C; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        check("same_bvalid", 256'(bus.BVALID), 256'(1'b1));
        e = bq.pop_front();
        check("same_bresp", 256'(bus.BRESP), 256'(e.resp));
        check("same_rvalid", 256'(bus.RVALID), 256'(1'b1));
        e = rq.pop_front();
        check("same_rdata_prewrite", 256'(bus.RDATA), 256'(e.data));
        check("same_ctrl_o", 256'(ctrl_o), 256'(model));
        @(negedge clk);
        axi_read(8'h0C, 32'h77, 2'b00, 0);

        // Reset while a B response is pending must drop it and the written state.
        bus.BREADY = 1'b0;
        bus.AWADDR = 8'h10; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h99; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        check("mid_bvalid", 256'(bus.BVALID), 256'(1'b1));
        check("mid_reg4", 256'(ctrl_o[159:128]), 256'(32'h99));
        @(negedge clk);
        check("mid_bvalid_held", 256'(bus.BVALID), 256'(1'b1));
        #2 rst = 1'b1;
        #1;
        model = '0;
        check("async_bvalid", 256'(bus.BVALID), 256'(1'b0));
        check("async_ctrl_o", 256'(ctrl_o), 256'(model));
        check("async_awready", 256'(bus.AWREADY), 256'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        bus.BREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_b_after_reset", 256'(bus.BVALID), 256'(1'b0));
        end
        check("post_reset_awready", 256'(bus.AWREADY), 256'(1'b1));
        model[4] = 32'h55;
        axi_write(8'h10, 32'h55, 4'hF, 0, 2'b00, 8'h10);
        axi_read(8'h04, 32'h0, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
